// File: rtl/rv32i_pkg.sv
// Shared RV32I constants for the fetch path.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0,x0,0 -- pipeline bubble encoding
  localparam logic [XLEN-1:0] NOP_ENCODING     = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

endpackage

// File: rtl/pc_register.sv
// Program counter register with next-PC selection.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   i_stall             : hold PC
//   i_branch_taken      : redirect request (wins over stall)
//   i_target_word       : redirect target, word address (bits [31:2])
//   o_pc                : PC register output, no logic after the flop
module pc_register
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = rv32i_pkg::RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_stall,
  input  logic            i_branch_taken,
  input  logic [XLEN-3:0] i_target_word,
  output logic [XLEN-1:0] o_pc
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;

  // Priority: redirect > stall > sequential (wraps modulo 2^32)
  always_comb begin
    w_pc_next = r_pc + PC_STEP;
    if (i_branch_taken) begin
      w_pc_next = {i_target_word, 2'b00};
    end else if (i_stall) begin
      w_pc_next = r_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register plus IF/ID pipeline register.
// Instruction memory lives outside; it reads Address_PC and returns
// Instruction combinationally.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   Stall, Flush               : hazard unit hold / squash requests
//   Branch_Taken, Branch_Target: redirect from EX
//   Address_PC                 : current PC to instruction memory
//   Instruction                : instruction memory read data
//   IFID_Instruction/PC/PC_Plus4/Valid : IF/ID register contents
//   Misaligned_Target          : one-cycle flag for a non-word-aligned target
module fetch_stage
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = rv32i_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_ENCODING
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Stall,
  input  logic            Flush,
  input  logic            Branch_Taken,
  input  logic [XLEN-1:0] Branch_Target,
  output logic [XLEN-1:0] Address_PC,
  input  logic [XLEN-1:0] Instruction,
  output logic [XLEN-1:0] IFID_Instruction,
  output logic [XLEN-1:0] IFID_PC,
  output logic [XLEN-1:0] IFID_PC_Plus4,
  output logic            IFID_Valid,
  output logic            Misaligned_Target
);

  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_squash;

  logic [XLEN-1:0] r_ifid_instr;
  logic [XLEN-1:0] r_ifid_pc;
  logic [XLEN-1:0] r_ifid_pc_plus4;
  logic            r_ifid_valid;
  logic            r_misaligned;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk            (clk),
    .rst            (rst),
    .i_stall        (Stall),
    .i_branch_taken (Branch_Taken),
    .i_target_word  (Branch_Target[XLEN-1:2]),
    .o_pc           (w_pc)
  );

  assign w_pc_plus4 = w_pc + PC_STEP;
  // A redirect squashes whatever is in IF this cycle
  assign w_squash   = Flush | Branch_Taken;

  // IF/ID register: reset > squash > stall > capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifid_instr    <= NOP_INSTR;
      r_ifid_pc       <= RESET_PC;
      r_ifid_pc_plus4 <= RESET_PC + PC_STEP;
      r_ifid_valid    <= 1'b0;
    end else if (w_squash) begin
      r_ifid_instr    <= NOP_INSTR;
      r_ifid_pc       <= w_pc;
      r_ifid_pc_plus4 <= w_pc_plus4;
      r_ifid_valid    <= 1'b0;
    end else if (!Stall) begin
      r_ifid_instr    <= Instruction;
      r_ifid_pc       <= w_pc;
      r_ifid_pc_plus4 <= w_pc_plus4;
      r_ifid_valid    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= Branch_Taken & (Branch_Target[1:0] != 2'b00);
    end
  end

  assign Address_PC        = w_pc;
  assign IFID_Instruction  = r_ifid_instr;
  assign IFID_PC           = r_ifid_pc;
  assign IFID_PC_Plus4     = r_ifid_pc_plus4;
  assign IFID_Valid        = r_ifid_valid;
  assign Misaligned_Target = r_misaligned;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: default-reset instance plus a wrap-around
// instance with RESET_PC = FFFF_FFF8.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst, stall, flush, bt;
  logic [31:0] target;
  logic [31:0] addr_pc, instr;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc4;
  logic        ifid_valid, misaligned;

  logic        rst1, zero1;
  logic [31:0] target1;
  logic [31:0] addr_pc1, instr1;
  logic [31:0] ifid_instr1, ifid_pc1, ifid_pc41;
  logic        ifid_valid1, misaligned1;

  logic [31:0] mem [0:63];
  int          total;
  int          passed;

  fetch_stage u_dut (
    .clk               (clk),
    .rst               (rst),
    .Stall             (stall),
    .Flush             (flush),
    .Branch_Taken      (bt),
    .Branch_Target     (target),
    .Address_PC        (addr_pc),
    .Instruction       (instr),
    .IFID_Instruction  (ifid_instr),
    .IFID_PC           (ifid_pc),
    .IFID_PC_Plus4     (ifid_pc4),
    .IFID_Valid        (ifid_valid),
    .Misaligned_Target (misaligned)
  );

  fetch_stage #(
    .RESET_PC (32'hFFFF_FFF8)
  ) u_dut_wrap (
    .clk               (clk),
    .rst               (rst1),
    .Stall             (zero1),
    .Flush             (zero1),
    .Branch_Taken      (zero1),
    .Branch_Target     (target1),
    .Address_PC        (addr_pc1),
    .Instruction       (instr1),
    .IFID_Instruction  (ifid_instr1),
    .IFID_PC           (ifid_pc1),
    .IFID_PC_Plus4     (ifid_pc41),
    .IFID_Valid        (ifid_valid1),
    .Misaligned_Target (misaligned1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instr  = mem[addr_pc[7:2]];
  assign instr1 = ~addr_pc1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_0113;
    mem[2] = 32'h0020_0193;
    mem[3] = 32'h0030_0213;

    rst = 1'b1; stall = 1'b0; flush = 1'b0; bt = 1'b0; target = 32'h0;
    rst1 = 1'b1; zero1 = 1'b0; target1 = 32'h0;
    edge_step();
    edge_step();

    // Reset state
    chk("rst_pc",     addr_pc,    32'h0);
    chk("rst_instr",  ifid_instr, NOP);
    chk("rst_ifidpc", ifid_pc,    32'h0);
    chk("rst_pc4",    ifid_pc4,   32'h4);
    chk("rst_valid",  32'(ifid_valid), 32'h0);
    chk("rst_mis",    32'(misaligned), 32'h0);

    // Free-running fetch
    rst = 1'b0;
    edge_step();
    chk("run1_pc",    addr_pc,    32'h4);
    chk("run1_ifpc",  ifid_pc,    32'h0);
    chk("run1_instr", ifid_instr, 32'h0050_0093);
    chk("run1_valid", 32'(ifid_valid), 32'h1);
    chk("run1_pc4",   ifid_pc4,   32'h4);
    edge_step();
    chk("run2_pc",    addr_pc,    32'h8);
    chk("run2_ifpc",  ifid_pc,    32'h4);
    chk("run2_instr", ifid_instr, 32'h0010_0113);

    // Stall two cycles at PC=8
    stall = 1'b1;
    edge_step();
    chk("st1_pc",    addr_pc, 32'h8);
    chk("st1_ifpc",  ifid_pc, 32'h4);
    edge_step();
    chk("st2_pc",    addr_pc, 32'h8);
    chk("st2_ifpc",  ifid_pc, 32'h4);
    chk("st2_instr", ifid_instr, 32'h0010_0113);
    stall = 1'b0;
    edge_step();
    chk("rs1_pc",    addr_pc, 32'hC);
    chk("rs1_ifpc",  ifid_pc, 32'h8);
    chk("rs1_instr", ifid_instr, 32'h0020_0193);
    edge_step();
    chk("rs2_pc",    addr_pc, 32'h10);
    chk("rs2_ifpc",  ifid_pc, 32'hC);

    // Taken branch to 0x40 at PC=0x10
    bt = 1'b1; target = 32'h40;
    edge_step();
    chk("br_pc",    addr_pc, 32'h40);
    chk("br_instr", ifid_instr, NOP);
    chk("br_valid", 32'(ifid_valid), 32'h0);
    chk("br_ifpc",  ifid_pc, 32'h10);
    chk("br_pc4",   ifid_pc4, 32'h14);
    chk("br_mis",   32'(misaligned), 32'h0);
    bt = 1'b0;
    edge_step();
    chk("brt_pc",    addr_pc, 32'h44);
    chk("brt_ifpc",  ifid_pc, 32'h40);
    chk("brt_valid", 32'(ifid_valid), 32'h1);
    chk("brt_instr", ifid_instr, 32'h1000_0010);

    // Misaligned redirect with stall: redirect still wins
    bt = 1'b1; stall = 1'b1; target = 32'h22;
    edge_step();
    chk("mis_pc",    addr_pc, 32'h20);
    chk("mis_flag",  32'(misaligned), 32'h1);
    chk("mis_instr", ifid_instr, NOP);
    chk("mis_valid", 32'(ifid_valid), 32'h0);
    chk("mis_ifpc",  ifid_pc, 32'h44);
    bt = 1'b0; stall = 1'b0;
    edge_step();
    chk("mis2_flag",  32'(misaligned), 32'h0);
    chk("mis2_pc",    addr_pc, 32'h24);
    chk("mis2_ifpc",  ifid_pc, 32'h20);
    chk("mis2_instr", ifid_instr, 32'h1000_0008);

    // Flush alone: PC advances, IF/ID bubble
    flush = 1'b1;
    edge_step();
    chk("fl_pc",    addr_pc, 32'h28);
    chk("fl_instr", ifid_instr, NOP);
    chk("fl_valid", 32'(ifid_valid), 32'h0);
    chk("fl_ifpc",  ifid_pc, 32'h24);
    // Flush with stall: PC holds, IF/ID still squashed
    stall = 1'b1;
    edge_step();
    chk("fls_pc",    addr_pc, 32'h28);
    chk("fls_ifpc",  ifid_pc, 32'h28);
    chk("fls_pc4",   ifid_pc4, 32'h2C);
    chk("fls_valid", 32'(ifid_valid), 32'h0);
    flush = 1'b0; stall = 1'b0;
    edge_step();
    chk("flr_ifpc",  ifid_pc, 32'h28);
    chk("flr_valid", 32'(ifid_valid), 32'h1);

    // Reset together with every control input: reset wins
    rst = 1'b1; bt = 1'b1; stall = 1'b1; flush = 1'b1; target = 32'h81;
    edge_step();
    chk("rb_pc",    addr_pc, 32'h0);
    chk("rb_instr", ifid_instr, NOP);
    chk("rb_ifpc",  ifid_pc, 32'h0);
    chk("rb_pc4",   ifid_pc4, 32'h4);
    chk("rb_valid", 32'(ifid_valid), 32'h0);
    chk("rb_mis",   32'(misaligned), 32'h0);
    rst = 1'b0; bt = 1'b0; stall = 1'b0; flush = 1'b0;
    edge_step();
    chk("rb2_pc",    addr_pc, 32'h4);
    chk("rb2_ifpc",  ifid_pc, 32'h0);
    chk("rb2_valid", 32'(ifid_valid), 32'h1);

    // PC wrap-around instance
    chk("wr0_pc",  addr_pc1, 32'hFFFF_FFF8);
    chk("wr0_pc4", ifid_pc41, 32'hFFFF_FFFC);
    rst1 = 1'b0;
    edge_step();
    chk("wr1_pc",    addr_pc1, 32'hFFFF_FFFC);
    chk("wr1_ifpc",  ifid_pc1, 32'hFFFF_FFF8);
    chk("wr1_instr", ifid_instr1, 32'h0000_0007);
    edge_step();
    chk("wr2_pc",    addr_pc1, 32'h0);
    chk("wr2_ifpc",  ifid_pc1, 32'hFFFF_FFFC);
    chk("wr2_pc4",   ifid_pc41, 32'h0);
    chk("wr2_valid", 32'(ifid_valid1), 32'h1);
    chk("wr2_mis",   32'(misaligned1), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset; SHALL be word-aligned.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), bubble encoding written into IF/ID.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 Stall  in  1  hazard unit hold request for PC and IF/ID.
REQ-006 Flush  in  1  hazard unit request to squash the IF/ID contents.
REQ-007 Branch_Taken  in  1  redirect from EX (taken branch, JAL, JALR).
REQ-008 Branch_Target  in  32  redirect address from EX.
REQ-009 Address_PC  out  32  current PC, driven straight to the instruction memory address port.
REQ-010 Instruction  in  32  combinational read data returned by the instruction memory for Address_PC.
REQ-011 IFID_Instruction  out  32  registered instruction to decode.
REQ-012 IFID_PC  out  32  registered PC of IFID_Instruction.
REQ-013 IFID_PC_Plus4  out  32  registered IFID_PC + 4, for JAL/JALR link.
REQ-014 IFID_Valid  out  1  1 = IF/ID holds a real instruction, 0 = bubble.
REQ-015 Misaligned_Target  out  1  registered one-cycle flag for a redirect target with bits [1:0] != 0.

Function
REQ-016 Address_PC SHALL be the PC register output directly, with zero combinational logic between register and port.
REQ-017 Next-PC priority, evaluated each edge: rst > Branch_Taken > Stall > sequential PC+4.
REQ-018 Branch_Taken=1: PC <= {Branch_Target[31:2],2'b00} on the next edge, even when Stall=1.
REQ-019 Stall=1 and Branch_Taken=0: PC SHALL hold its value.
REQ-020 Sequential increment SHALL be modulo 2^32; PC 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000 without a flag.
REQ-021 IF/ID update priority: rst > (Flush or Branch_Taken) > Stall > capture.
REQ-022 Flush=1 or Branch_Taken=1: IFID_Instruction <= NOP_INSTR, IFID_Valid <= 0. IFID_PC and IFID_PC_Plus4 load Address_PC and Address_PC+4. Applies even when Stall=1.
REQ-023 Stall=1 with no flush or redirect: all IF/ID outputs SHALL hold.
REQ-024 Capture: IFID_Instruction <= Instruction, IFID_PC <= Address_PC, IFID_PC_Plus4 <= Address_PC+4, IFID_Valid <= 1.
REQ-025 Fetch latency: an instruction at PC appears on IFID_* exactly one edge after Address_PC = PC with no stall.
REQ-026 Redirect penalty: the instruction in IF on the Branch_Taken edge SHALL be squashed. The target instruction SHALL reach IF/ID on the second edge after redirect.
REQ-027 Misaligned_Target <= Branch_Taken & (Branch_Target[1:0] != 0) on every edge; it is otherwise 0.

Reset
REQ-028 rst=1 at an edge: PC <= RESET_PC, IFID_Instruction <= NOP_INSTR, IFID_PC <= RESET_PC, IFID_PC_Plus4 <= RESET_PC+4, IFID_Valid <= 0, Misaligned_Target <= 0.
REQ-029 rst overrides Stall, Flush and Branch_Taken asserted in the same cycle.
REQ-030 First edge after rst deasserts (no stall): IF/ID captures the instruction at RESET_PC with IFID_Valid=1.

Structure
REQ-031 Shared package rv32i_pkg SHALL hold XLEN=32, NOP_INSTR encoding and RESET_PC default.
REQ-032 PC register with next-PC mux SHALL be sub-module pc_register. IF/ID register logic resides in fetch_stage.
REQ-033 fetch_stage SHALL NOT instantiate the instruction memory. The memory connects at the top level via Address_PC/Instruction.

Verification
REQ-034 Reset, then 4 free-running edges with memory loaded 0x00500093,0x00100113,… -> Address_PC 0,4,8,C,10. IFID_PC lags by one edge. IFID_Valid=1 from the first post-reset edge.
REQ-035 Stall=1 for 2 cycles at PC=8 -> Address_PC stays 8 and IFID_PC stays 4 for 2 edges, then resumes 0xC.
REQ-036 Branch_Taken=1 with target 0x40 at PC=0x10 -> next Address_PC=0x40, IFID_Valid=0 with NOP, then IFID_PC=0x40 with Valid=1.
REQ-037 Branch_Taken=1 and Stall=1 together with target 0x22 -> PC=0x20, Misaligned_Target=1 for one cycle, IF/ID bubble.
REQ-038 RESET_PC=32'hFFFF_FFF8 -> Address_PC FFFF_FFF8, FFFF_FFFC, 0000_0000. IFID_PC_Plus4 for FFFF_FFFC equals 0.
REQ-039 rst=1 asserted mid-stream together with Branch_Taken=1 -> all outputs at REQ-028 values, and the redirect is ignored.
